traffic_density_monitor: RTL and testbench

Vehicle-detector front end for the smart traffic light. It debounces three raw loop-detector inputs, one per lane group, and counts vehicles per lane over a fixed window of one-second ticks. At each window end it classifies every lane as low or high traffic and drives the `L[2:0]` and `H[2:0]` buses consumed by the traffic-light controller. It sits directly upstream of the controller and shares its clock and reset.

---
 rtl/traffic_density_monitor.sv | 145 ++++++++++++++
 tb/tb_traffic_density_monitor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_density_monitor.sv
// Loop-detector front end: synchronizes and debounces three lanes, counts vehicles
// per lane over a window of sec_tick pulses, and classifies each lane as low/high.
module traffic_density_monitor #(
  parameter int DEB_CYCLES = 4,
  parameter int WIN_SEC    = 10,
  parameter int LOW_TH     = 2,
  parameter int HIGH_TH    = 6,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [2:0] det,
  output logic [2:0] L,
  output logic [2:0] H,
  output logic       upd,
  output logic [3:0] win_cnt
);

  typedef enum logic {
    STABLE_LO = 1'b0,
    STABLE_HI = 1'b1
  } deb_state_e;

  localparam int               DW       = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0]    DEB_MAX  = DW'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] LOW_V    = CNT_W'(LOW_TH);
  localparam logic [CNT_W-1:0] HIGH_V   = CNT_W'(HIGH_TH);
  localparam logic [3:0]       WIN_LAST = 4'(WIN_SEC - 1);

  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  deb_state_e       state_q   [3];
  deb_state_e       state_d   [3];
  logic [DW-1:0]    deb_cnt_q [3];
  logic [DW-1:0]    deb_cnt_d [3];
  logic [2:0]       veh_q, veh_d;
  logic [CNT_W-1:0] lane_cnt_q [3];
  logic [CNT_W-1:0] lane_cnt_d [3];
  logic [CNT_W-1:0] c_cur      [3];
  logic [3:0]       win_q, win_d;
  logic [2:0]       l_q, l_d;
  logic [2:0]       h_q, h_d;
  logic             upd_q, upd_d;
  logic             close;

  // Two-flop synchronizer on the raw detector lines.
  always_comb begin
    sync1_d = det;
    sync2_d = sync1_q;
  end

  // Debounce FSM per lane: the level flips only after DEB_CYCLES+1 consecutive
  // differing samples, i.e. once the stability counter has reached DEB_CYCLES.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    veh_d = 3'b000;
    for (int i = 0; i < 3; i++) begin
      state_d[i]   = state_q[i];
      deb_cnt_d[i] = '0;
      case (state_q[i])
        STABLE_LO: begin
          if (sync2_q[i]) begin
            if (deb_cnt_q[i] == DEB_MAX) begin
              state_d[i] = STABLE_HI;
              veh_d[i]   = 1'b1;
            end else begin
              deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
          end
        end
        STABLE_HI: begin
          if (!sync2_q[i]) begin
            if (deb_cnt_q[i] == DEB_MAX) begin
              state_d[i] = STABLE_LO;
            end else begin
              deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
          end
        end
        default: state_d[i] = STABLE_LO;
      endcase
    end
  end

  assign close = sec_tick && (win_q == WIN_LAST);

  // Window bookkeeping; a vehicle landing on the closing tick belongs to the closing window.
  always_comb begin
    win_d = win_q;
    upd_d = close;
    l_d   = l_q;
    h_d   = h_q;
    if (sec_tick) begin
      win_d = close ? 4'd0 : win_q + 4'd1;
    end
    for (int i = 0; i < 3; i++) begin
      c_cur[i]      = (veh_q[i] && (lane_cnt_q[i] != CNT_SAT)) ? lane_cnt_q[i] + 1'b1
                                                                : lane_cnt_q[i];
      lane_cnt_d[i] = close ? '0 : c_cur[i];
      if (close) begin
        h_d[i] = (c_cur[i] >= HIGH_V);
        l_d[i] = (c_cur[i] <= LOW_V);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      veh_q   <= '0;
      win_q   <= '0;
      l_q     <= '0;
      h_q     <= '0;
      upd_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        state_q[i]    <= STABLE_LO;
        deb_cnt_q[i]  <= '0;
        lane_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      veh_q   <= veh_d;
      win_q   <= win_d;
      l_q     <= l_d;
      h_q     <= h_d;
      upd_q   <= upd_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i]    <= state_d[i];
        deb_cnt_q[i]  <= deb_cnt_d[i];
        lane_cnt_q[i] <= lane_cnt_d[i];
      end
    end
  end

  assign L       = l_q;
  assign H       = h_q;
  assign upd     = upd_q;
  assign win_cnt = win_q;

endmodule

// File: tb/tb_traffic_density_monitor.sv
// Self-checking bench: table of per-lane vehicle counts with expected L/H, a scoreboard
// popped on every upd, and hand sequences for glitches, same-cycle events and resets.
module tb_traffic_density_monitor;

  localparam int WIN_SEC = 10;
  localparam int NV      = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       sec_tick;
  logic [2:0] det;
  logic [2:0] L;
  logic [2:0] H;
  logic       upd;
  logic [3:0] win_cnt;

  int checks = 0;
  int errors = 0;
  int win_m  = 0;
  logic upd_prev = 1'b0;

  typedef struct {
    int         n0;
    int         n1;
    int         n2;
    logic [2:0] exp_l;
    logic [2:0] exp_h;
  } vec_t;

  typedef struct packed {
    logic [2:0] l;
    logic [2:0] h;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb_q [$];
  exp_t sb_e;

  traffic_density_monitor #(
    .DEB_CYCLES(4),
    .WIN_SEC   (WIN_SEC),
    .LOW_TH    (2),
    .HIGH_TH   (6),
    .CNT_W     (5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sec_tick(sec_tick),
    .det     (det),
    .L       (L),
    .H       (H),
    .upd     (upd),
    .win_cnt (win_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean vehicles: 10 cycles present, 10 cycles absent, lanes in parallel.
  task automatic pulses(input int n0, input int n1, input int n2);
    int m;
    m = n0;
    if (n1 > m) m = n1;
    if (n2 > m) m = n2;
    for (int k = 0; k < m; k++) begin
      det[0] = (k < n0);
      det[1] = (k < n1);
      det[2] = (k < n2);
      step(10);
      det = 3'b000;
      step(10);
    end
  endtask

  task automatic tick_once(input logic [2:0] el, input logic [2:0] eh);
    logic closing;
    closing = (win_m == WIN_SEC - 1);
    if (closing) sb_q.push_back('{l: el, h: eh});
    sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
    win_m = closing ? 0 : win_m + 1;
    check("win_cnt_track", win_cnt, win_m);
    check("upd_at_tick", upd, closing);
    step(1);
    check("upd_after_tick", upd, 1'b0);
  endtask

  task automatic finish_window(input logic [2:0] el, input logic [2:0] eh);
    while (win_m != WIN_SEC - 1) tick_once(3'b000, 3'b000);
    tick_once(el, eh);
  endtask

  task automatic advance_to(input int pos);
    while (win_m != pos) tick_once(3'b000, 3'b000);
  endtask

  // Scoreboard: every upd must match the oldest pending window expectation.
  always @(negedge clk) begin
    if (upd) begin
      check("upd_width", upd_prev, 1'b0);
      check("sb_pending", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        check("sb_L", L, sb_e.l);
        check("sb_H", H, sb_e.h);
        check("lh_exclusive", L & H, 3'b000);
      end
    end
    upd_prev = upd;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    vecs[0] = '{2, 4, 6, 3'b001, 3'b100};
    vecs[1] = '{0, 0, 0, 3'b111, 3'b000};
    vecs[2] = '{3, 6, 2, 3'b100, 3'b010};
    vecs[3] = '{7, 1, 5, 3'b010, 3'b001};
    vecs[4] = '{0, 40, 0, 3'b101, 3'b010};
    vecs[5] = '{0, 34, 0, 3'b101, 3'b010};
    vecs[6] = '{6, 2, 3, 3'b010, 3'b001};

    // Reset with all detectors active.
    reset    = 1'b1;
    sec_tick = 1'b0;
    det      = 3'b111;
    step(2);
    check("reset_L", L, 3'b000);
    check("reset_H", H, 3'b000);
    check("reset_upd", upd, 1'b0);
    check("reset_win", win_cnt, 4'd0);
    reset = 1'b0;
    win_m = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("post_reset_win", win_cnt, 4'd0);
      check("post_reset_upd", upd, 1'b0);
    end
    det = 3'b000;
    step(10);

    // Short glitch on lane 0, then 8 clean vehicles.
    det = 3'b001;
    step(3);
    det = 3'b000;
    step(10);
    pulses(8, 0, 0);
    finish_window(3'b110, 3'b001);

    // Three sub-threshold glitches on every lane must not count.
    for (int g = 0; g < 3; g++) begin
      det = 3'b111;
      step(3);
      det = 3'b000;
      step(10);
    end
    pulses(0, 2, 2);
    finish_window(3'b111, 3'b000);

    // Sixth lane-2 vehicle lands in the closing-tick cycle.
    pulses(0, 0, 5);
    advance_to(WIN_SEC - 1);
    det = 3'b100;
    step(7);
    tick_once(3'b011, 3'b100);
    step(5);
    det = 3'b000;
    step(10);
    pulses(0, 0, 2);
    finish_window(3'b111, 3'b000);

    // Table-driven windows.
    for (int t = 0; t < NV; t++) begin
      pulses(vecs[t].n0, vecs[t].n1, vecs[t].n2);
      finish_window(vecs[t].exp_l, vecs[t].exp_h);
    end

    // Reset mid-window (coinciding with a non-closing tick).
    pulses(7, 0, 0);
    advance_to(5);
    reset    = 1'b1;
    sec_tick = 1'b1;
    step(1);
    reset    = 1'b0;
    sec_tick = 1'b0;
    win_m    = 0;
    check("midreset_L", L, 3'b000);
    check("midreset_H", H, 3'b000);
    check("midreset_win", win_cnt, 4'd0);
    check("midreset_upd", upd, 1'b0);
    finish_window(3'b111, 3'b000);

    // Reset together with the closing tick: no upd.
    advance_to(WIN_SEC - 1);
    reset    = 1'b1;
    sec_tick = 1'b1;
    step(1);
    reset    = 1'b0;
    sec_tick = 1'b0;
    win_m    = 0;
    check("reset_close_upd", upd, 1'b0);
    check("reset_close_win", win_cnt, 4'd0);
    check("reset_close_L", L, 3'b000);
    step(2);
    check("reset_close_upd_later", upd, 1'b0);

    check("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
